// File: rtl/expr_stream_checker_if.sv
// Character-stream bundle for expr_stream_checker: byte in, verdict and counters out.
interface expr_stream_checker_if #(
    parameter int CNT_W     = 8,
    parameter int MAX_DEPTH = 7,
    parameter int DW        = $clog2(MAX_DEPTH + 1)
);
    logic             in_valid;
    logic [7:0]       in;
    logic             out;
    logic             err;
    logic [CNT_W-1:0] operands;
    logic [DW-1:0]    depth;

    modport master (
        output in_valid,
        output in,
        input  out,
        input  err,
        input  operands,
        input  depth
    );

    modport slave (
        input  in_valid,
        input  in,
        output out,
        output err,
        output operands,
        output depth
    );
endinterface

// File: rtl/expr_stream_checker.sv
// Streaming ASCII expression validator (digits, + - * /, optional brackets).
// Bracket support is compiled in with `define EXPR_PAREN_EN.
module expr_stream_checker #(
    parameter int MAX_DIGITS = 4,
    parameter int MAX_DEPTH  = 7,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    expr_stream_checker_if.slave  bus
);
    localparam int DW = $clog2(MAX_DEPTH + 1);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] DIG_MAX = CW'(MAX_DIGITS);

    localparam logic [1:0] S_EXP = 2'd0;
    localparam logic [1:0] S_NUM = 2'd1;
    localparam logic [1:0] S_ERR = 2'd3;
`ifdef EXPR_PAREN_EN
    localparam logic [1:0] S_CLS = 2'd2;
    localparam logic [DW-1:0] DEP_MAX = DW'(MAX_DEPTH);
`endif

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    dcnt_q, dcnt_d;
    logic [CNT_W-1:0] ops_q, ops_d;
    logic             is_d, is_o;
`ifdef EXPR_PAREN_EN
    logic             is_l, is_r;
    logic [DW-1:0]    depth_q, depth_d;
`endif

    always_comb begin
        is_d = (bus.in >= 8'h30) && (bus.in <= 8'h39);
        is_o = (bus.in == 8'h2B) || (bus.in == 8'h2D) ||
               (bus.in == 8'h2A) || (bus.in == 8'h2F);
`ifdef EXPR_PAREN_EN
        is_l = (bus.in == 8'h28);
        is_r = (bus.in == 8'h29);
`endif
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        ops_d   = ops_q;
`ifdef EXPR_PAREN_EN
        depth_d = depth_q;
`endif
        if (bus.in_valid) begin
            case (state_q)
                S_EXP: begin
                    if (is_d) begin
                        state_d = S_NUM;
                        dcnt_d  = CW'(1);
                        if (ops_q != '1) begin
                            ops_d = ops_q + CNT_W'(1);
                        end
                    end
`ifdef EXPR_PAREN_EN
                    else if (is_l) begin
                        if (depth_q == DEP_MAX) begin
                            state_d = S_ERR;
                        end else begin
                            depth_d = depth_q + DW'(1);
                        end
                    end
`endif
                    else begin
                        state_d = S_ERR;
                    end
                end
                S_NUM: begin
                    if (is_d) begin
                        if (dcnt_q < DIG_MAX) begin
                            dcnt_d = dcnt_q + CW'(1);
                        end else begin
                            state_d = S_ERR;
                        end
                    end else if (is_o) begin
                        state_d = S_EXP;
                    end
`ifdef EXPR_PAREN_EN
                    else if (is_r && (depth_q != '0)) begin
                        state_d = S_CLS;
                        depth_d = depth_q - DW'(1);
                    end
`endif
                    else begin
                        state_d = S_ERR;
                    end
                end
`ifdef EXPR_PAREN_EN
                S_CLS: begin
                    if (is_o) begin
                        state_d = S_EXP;
                    end else if (is_r && (depth_q != '0)) begin
                        depth_d = depth_q - DW'(1);
                    end else begin
                        state_d = S_ERR;
                    end
                end
`endif
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_ERR;
                end
            endcase
            // Run length only matters while inside a number.
            if (state_d != S_NUM) begin
                dcnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_EXP;
            dcnt_q  <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            ops_q   <= ops_d;
        end
    end

`ifdef EXPR_PAREN_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    assign bus.out   = ((state_q == S_NUM) || (state_q == S_CLS)) &&
                       (depth_q == '0);
    assign bus.depth = depth_q;
`else
    assign bus.out   = (state_q == S_NUM);
    assign bus.depth = {DW{1'b0}};
`endif

    assign bus.err      = (state_q == S_ERR);
    assign bus.operands = ops_q;
endmodule
